// File: rtl/complete_arbiter.sv
// Completion-stage arbiter feeding the CDB mux: fixed-latency FUs win lanes first,
// variable-latency FUs share what is left round-robin, with starvation-driven lane reservation.
module complete_arbiter #(
  parameter int NUM_LANES     = 3,
  parameter int NUM_FU_ALU    = 3,
  parameter int NUM_FU_MULT   = 2,
  parameter int NUM_FU_BRANCH = 1,
  parameter int NUM_FU_LDST   = 1,
  parameter int STARVE_LIMIT  = 4,
  localparam int TOTAL = NUM_FU_LDST + NUM_FU_MULT + NUM_FU_ALU + NUM_FU_BRANCH,
  localparam int SW    = $clog2(NUM_LANES + 1)
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic [NUM_FU_ALU-1:0]               alu_req,
  input  logic [NUM_FU_BRANCH-1:0]            branch_req,
  input  logic [NUM_FU_MULT-1:0]              mult_cdb_valid,
  input  logic [NUM_FU_LDST-1:0]              ldst_cdb_valid,
  output logic [NUM_LANES-1:0][TOTAL-1:0]     complete_gnt_bus,
  output logic [NUM_FU_MULT-1:0]              mult_cdb_en,
  output logic [NUM_FU_LDST-1:0]              ldst_cdb_en,
  output logic [SW-1:0]                       fixed_slots_avail,
  output logic                                overcommit_err
);

  localparam int V  = NUM_FU_LDST + NUM_FU_MULT;
  localparam int F  = NUM_FU_ALU + NUM_FU_BRANCH;
  localparam int PW = (V > 1) ? $clog2(V) : 1;
  localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

  logic [PW-1:0]               r_rrPtr;
  logic [V-1:0][2:0]           r_age;
  logic [SW-1:0]               r_fixedSlots;
  logic                        r_overcommit;

  logic [F-1:0]                w_fixedReq;
  logic [V-1:0]                w_varReq;
  logic [NUM_LANES-1:0][TOTAL-1:0] w_gnt;
  logic [V-1:0]                w_varGnt;
  logic                        w_drop;
  logic                        w_anyVar;
  logic [PW-1:0]               w_lastVar;
  logic [V-1:0][2:0]           w_ageNext;
  logic [SW-1:0]               w_slotsNext;
  logic [PW-1:0]               w_rrNext;

  assign w_fixedReq = {branch_req, alu_req};
  assign w_varReq   = {mult_cdb_valid, ldst_cdb_valid};

  // Fixed FUs fill lanes from 0 upward; variable FUs then scan circularly from r_rrPtr.
  always_comb begin
    int lane;
    int idx;
    w_gnt     = '0;
    w_varGnt  = '0;
    w_drop    = 1'b0;
    w_anyVar  = 1'b0;
    w_lastVar = r_rrPtr;
    lane      = 0;
    idx       = 0;
    if (!reset) begin
      for (int k = 0; k < F; k++) begin
        if (w_fixedReq[k]) begin
          if (lane < NUM_LANES) begin
            w_gnt[lane][V + k] = 1'b1;
            lane++;
          end else begin
            w_drop = 1'b1;
          end
        end
      end
      for (int j = 0; j < V; j++) begin
        idx = int'(r_rrPtr) + j;
        if (idx >= V) idx = idx - V;
        if (w_varReq[idx] && lane < NUM_LANES) begin
          w_gnt[lane][idx] = 1'b1;
          w_varGnt[idx]    = 1'b1;
          w_anyVar         = 1'b1;
          w_lastVar        = PW'(idx);
          lane++;
        end
      end
    end
  end

  // A FU granted on the cycle it would saturate clears instead, so it never reserves a lane.
  always_comb begin
    int starved;
    starved = 0;
    for (int i = 0; i < V; i++) begin
      if (w_varReq[i] && !w_varGnt[i]) begin
        w_ageNext[i] = (r_age[i] >= LIMIT) ? LIMIT : r_age[i] + 3'd1;
      end else begin
        w_ageNext[i] = 3'd0;
      end
      if (w_ageNext[i] == LIMIT) starved++;
    end
    if (starved > NUM_LANES) starved = NUM_LANES;
    w_slotsNext = SW'(NUM_LANES - starved);
  end

  assign w_rrNext = (w_lastVar == PW'(V - 1)) ? '0 : w_lastVar + PW'(1);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_rrPtr      <= '0;
      r_age        <= '0;
      r_fixedSlots <= SW'(NUM_LANES);
      r_overcommit <= 1'b0;
    end else begin
      if (w_anyVar) r_rrPtr <= w_rrNext;
      r_age        <= w_ageNext;
      r_fixedSlots <= w_slotsNext;
      r_overcommit <= r_overcommit | w_drop;
    end
  end

  assign complete_gnt_bus  = w_gnt;
  assign ldst_cdb_en       = w_varGnt[NUM_FU_LDST-1:0];
  assign mult_cdb_en       = w_varGnt[V-1:NUM_FU_LDST];
  assign fixed_slots_avail = r_fixedSlots;
  assign overcommit_err    = r_overcommit;

endmodule

// File: tb/tb_complete_arbiter.sv
// Scoreboard bench for complete_arbiter: expected lane grants are queued as stimulus is
// driven and popped when the combinational outputs are sampled on the falling edge.
module tb_complete_arbiter;

  logic             clock = 1'b0;
  logic             reset;
  logic [2:0]       alu_req;
  logic [0:0]       branch_req;
  logic [1:0]       mult_cdb_valid;
  logic [0:0]       ldst_cdb_valid;
  logic [2:0][6:0]  complete_gnt_bus;
  logic [1:0]       mult_cdb_en;
  logic [0:0]       ldst_cdb_en;
  logic [1:0]       fixed_slots_avail;
  logic             overcommit_err;

  typedef struct packed {
    logic [2:0][6:0] gnt;
    logic [1:0]      men;
    logic            len;
  } exp_t;

  exp_t sbQ[$];
  int   errors = 0;
  int   checks = 0;

  complete_arbiter dut (
    .clock            (clock),
    .reset            (reset),
    .alu_req          (alu_req),
    .branch_req       (branch_req),
    .mult_cdb_valid   (mult_cdb_valid),
    .ldst_cdb_valid   (ldst_cdb_valid),
    .complete_gnt_bus (complete_gnt_bus),
    .mult_cdb_en      (mult_cdb_en),
    .ldst_cdb_en      (ldst_cdb_en),
    .fixed_slots_avail(fixed_slots_avail),
    .overcommit_err   (overcommit_err)
  );

  always #5 clock = ~clock;

  // FU index map: ldst=0, mult0=1, mult1=2, alu=3..5, branch=6; -1 means an empty lane.
  function automatic logic [6:0] oh(input int idx);
    logic [6:0] v;
    v = '0;
    if (idx >= 0) v[idx] = 1'b1;
    return v;
  endfunction

  task automatic applyStimulus(input logic rst, input logic [2:0] alu, input logic br,
                               input logic [1:0] mv, input logic lv,
                               input int l0, input int l1, input int l2,
                               input logic [1:0] men, input logic len);
    exp_t e;
    @(posedge clock);
    #1;
    reset          = rst;
    alu_req        = alu;
    branch_req     = br;
    mult_cdb_valid = mv;
    ldst_cdb_valid = lv;
    e.gnt = {oh(l2), oh(l1), oh(l0)};
    e.men = men;
    e.len = len;
    sbQ.push_back(e);
    @(negedge clock);
  endtask

  task automatic test_reset();
    exp_t e;
    for (int c = 0; c < 2; c++) begin
      applyStimulus(1'b1, 3'b111, 1'b1, 2'b11, 1'b1, -1, -1, -1, 2'b00, 1'b0);
      e = sbQ.pop_front();
      checks++;
      if ({complete_gnt_bus, mult_cdb_en, ldst_cdb_en} !== e) begin
        errors++;
        $display("[TB] FAIL reset_gnt cycle %0d: got %h want %h", c, {complete_gnt_bus, mult_cdb_en, ldst_cdb_en}, e);
      end
      checks++;
      if (fixed_slots_avail !== 2'd3) begin
        errors++;
        $display("[TB] FAIL reset_slots: got %0d want 3", fixed_slots_avail);
      end
    end
    applyStimulus(1'b0, 3'b111, 1'b0, 2'b00, 1'b0, 3, 4, 5, 2'b00, 1'b0);
    e = sbQ.pop_front();
    checks++;
    if ({complete_gnt_bus, mult_cdb_en, ldst_cdb_en} !== e) begin
      errors++;
      $display("[TB] FAIL alu_fill: got %h want %h", {complete_gnt_bus, mult_cdb_en, ldst_cdb_en}, e);
    end
    checks++;
    if (overcommit_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL err_after_reset: got %b want 0", overcommit_err);
    end
  endtask

  task automatic test_mixed_rr();
    exp_t e;
    applyStimulus(1'b0, 3'b001, 1'b0, 2'b11, 1'b1, 3, 0, 1, 2'b01, 1'b1);
    e = sbQ.pop_front();
    checks++;
    if ({complete_gnt_bus, mult_cdb_en, ldst_cdb_en} !== e) begin
      errors++;
      $display("[TB] FAIL mixed_rr0: got %h want %h", {complete_gnt_bus, mult_cdb_en, ldst_cdb_en}, e);
    end
    // rr_ptr is now 2, so the scan starts at mult1 and wraps to ldst, mult0.
    applyStimulus(1'b0, 3'b000, 1'b0, 2'b11, 1'b1, 2, 0, 1, 2'b11, 1'b1);
    e = sbQ.pop_front();
    checks++;
    if ({complete_gnt_bus, mult_cdb_en, ldst_cdb_en} !== e) begin
      errors++;
      $display("[TB] FAIL mixed_rr2: got %h want %h", {complete_gnt_bus, mult_cdb_en, ldst_cdb_en}, e);
    end
  endtask

  task automatic test_starvation();
    exp_t e;
    logic [1:0] wantSlots [7] = '{2'd3, 2'd3, 2'd3, 2'd3, 2'd2, 2'd2, 2'd3};
    for (int c = 0; c < 7; c++) begin
      if (c < 5)       applyStimulus(1'b0, 3'b111, 1'b0, 2'b10, 1'b0, 3, 4, 5, 2'b00, 1'b0);
      else if (c == 5) applyStimulus(1'b0, 3'b011, 1'b0, 2'b10, 1'b0, 3, 4, 2, 2'b10, 1'b0);
      else             applyStimulus(1'b0, 3'b000, 1'b0, 2'b00, 1'b0, -1, -1, -1, 2'b00, 1'b0);
      e = sbQ.pop_front();
      checks++;
      if ({complete_gnt_bus, mult_cdb_en, ldst_cdb_en} !== e) begin
        errors++;
        $display("[TB] FAIL starve_gnt cycle %0d: got %h want %h", c, {complete_gnt_bus, mult_cdb_en, ldst_cdb_en}, e);
      end
      checks++;
      if (fixed_slots_avail !== wantSlots[c]) begin
        errors++;
        $display("[TB] FAIL starve_slots cycle %0d: got %0d want %0d", c, fixed_slots_avail, wantSlots[c]);
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    for (int c = 0; c < 2; c++) begin
      applyStimulus(1'b0, 3'b000, 1'b0, 2'b11, 1'b1, 0, 1, 2, 2'b11, 1'b1);
      e = sbQ.pop_front();
      checks++;
      if ({complete_gnt_bus, mult_cdb_en, ldst_cdb_en} !== e) begin
        errors++;
        $display("[TB] FAIL var_b2b cycle %0d: got %h want %h", c, {complete_gnt_bus, mult_cdb_en, ldst_cdb_en}, e);
      end
    end
  endtask

  task automatic test_overcommit();
    exp_t e;
    applyStimulus(1'b0, 3'b111, 1'b1, 2'b00, 1'b0, 3, 4, 5, 2'b00, 1'b0);
    e = sbQ.pop_front();
    checks++;
    if ({complete_gnt_bus, mult_cdb_en, ldst_cdb_en} !== e) begin
      errors++;
      $display("[TB] FAIL overcommit_gnt: got %h want %h", {complete_gnt_bus, mult_cdb_en, ldst_cdb_en}, e);
    end
    checks++;
    if (overcommit_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL overcommit_early: got %b want 0", overcommit_err);
    end
    for (int c = 0; c < 2; c++) begin
      applyStimulus(1'b0, 3'b000, 1'b0, 2'b00, 1'b0, -1, -1, -1, 2'b00, 1'b0);
      e = sbQ.pop_front();
      checks++;
      if ({complete_gnt_bus, mult_cdb_en, ldst_cdb_en} !== e) begin
        errors++;
        $display("[TB] FAIL idle_gnt cycle %0d: got %h want %h", c, {complete_gnt_bus, mult_cdb_en, ldst_cdb_en}, e);
      end
      checks++;
      if (overcommit_err !== 1'b1) begin
        errors++;
        $display("[TB] FAIL overcommit_sticky cycle %0d: got %b want 1", c, overcommit_err);
      end
    end
  endtask

  task automatic test_single_var();
    exp_t e;
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1'b0, 3'b000, 1'b0, 2'b01, 1'b0, 1, -1, -1, 2'b01, 1'b0);
      e = sbQ.pop_front();
      checks++;
      if ({complete_gnt_bus, mult_cdb_en, ldst_cdb_en} !== e) begin
        errors++;
        $display("[TB] FAIL single_var cycle %0d: got %h want %h", c, {complete_gnt_bus, mult_cdb_en, ldst_cdb_en}, e);
      end
      checks++;
      if (fixed_slots_avail !== 2'd3) begin
        errors++;
        $display("[TB] FAIL single_var_slots cycle %0d: got %0d want 3", c, fixed_slots_avail);
      end
    end
  endtask

  task automatic test_reset_midop();
    exp_t e;
    applyStimulus(1'b1, 3'b111, 1'b0, 2'b11, 1'b1, -1, -1, -1, 2'b00, 1'b0);
    e = sbQ.pop_front();
    checks++;
    if ({complete_gnt_bus, mult_cdb_en, ldst_cdb_en} !== e) begin
      errors++;
      $display("[TB] FAIL midreset_gnt: got %h want %h", {complete_gnt_bus, mult_cdb_en, ldst_cdb_en}, e);
    end
    applyStimulus(1'b0, 3'b000, 1'b0, 2'b00, 1'b0, -1, -1, -1, 2'b00, 1'b0);
    e = sbQ.pop_front();
    checks++;
    if ({complete_gnt_bus, mult_cdb_en, ldst_cdb_en} !== e) begin
      errors++;
      $display("[TB] FAIL midreset_idle: got %h want %h", {complete_gnt_bus, mult_cdb_en, ldst_cdb_en}, e);
    end
    checks++;
    if (overcommit_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midreset_err: got %b want 0", overcommit_err);
    end
    checks++;
    if (fixed_slots_avail !== 2'd3) begin
      errors++;
      $display("[TB] FAIL midreset_slots: got %0d want 3", fixed_slots_avail);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset          = 1'b1;
    alu_req        = 3'b111;
    branch_req     = 1'b1;
    mult_cdb_valid = 2'b11;
    ldst_cdb_valid = 1'b1;
    test_reset();
    test_mixed_rr();
    test_starvation();
    test_back_to_back();
    test_overcommit();
    test_single_var();
    test_reset_midop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/complete_arbiter.md
Name: complete_arbiter

Overview:
- Completion-stage arbiter directly upstream of the execute stage's CDB mux.
- Each cycle, grants up to NUM_LANES CDB lanes to functional units:
  - fixed-latency FUs (ALU, branch) are granted unconditionally;
  - variable-latency FUs (mult, ldst) share the leftover lanes in round-robin order.
- Drives `complete_gnt_bus` and the mult/ldst `cdb_en` strobes.
- Tells the issue stage how many fixed-latency issues it may make this cycle; lanes are reserved for variable FUs that have waited too long.

Parameters:
- NUM_LANES, 3, CDB lanes per cycle (`N`).
- NUM_FU_ALU, 3, ALU count.
- NUM_FU_MULT, 2, multiplier count.
- NUM_FU_BRANCH, 1, branch unit count.
- NUM_FU_LDST, 1, load/store unit count.
- STARVE_LIMIT, 4, consecutive ungranted cycles before a variable FU forces a lane reservation.
- TOTAL (derived), NUM_FU_LDST+NUM_FU_MULT+NUM_FU_ALU+NUM_FU_BRANCH.
- FU index map, LSB first: ldst [0..L-1], mult [L..L+M-1], alu, branch.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- alu_req  in  NUM_FU_ALU  ALU holds a valid executing packet this cycle
- branch_req  in  NUM_FU_BRANCH  branch unit holds a valid packet this cycle
- mult_cdb_valid  in  NUM_FU_MULT  multiplier result ready, held until granted
- ldst_cdb_valid  in  NUM_FU_LDST  ldst result ready, held until granted
- complete_gnt_bus  out  NUM_LANES x TOTAL  one-hot-or-zero grant per lane
- mult_cdb_en  out  NUM_FU_MULT  mult granted this cycle
- ldst_cdb_en  out  NUM_FU_LDST  ldst granted this cycle
- fixed_slots_avail  out  $clog2(NUM_LANES+1)  max ALU+branch issues allowed this cycle (registered)
- overcommit_err  out  1  sticky; fixed requests exceeded available lanes

Behaviour:
- Reset state:
  - rr_ptr = 0;
  - all age counters = 0;
  - fixed_slots_avail = NUM_LANES;
  - overcommit_err = 0.
- Grant outputs are combinational from the current requests and registered state. They are zero whenever there are no requests, including the cycle reset is asserted.
- Lane allocation, combinational, same cycle as request:
  - Fixed requests take the lowest-numbered lanes in ascending FU index order.
  - Remaining lanes go to variable requests (ldst+mult, local indices 0..L+M-1), scanning circularly from rr_ptr.
  - Each FU gets at most one lane.
  - Each lane has at most one bit set.
  - Unused lanes are all-zero.
- Ungranted fixed requests (more than NUM_LANES) are dropped: no grant, and overcommit_err is set the next cycle and stays set until reset.
- cdb_en[i] = OR over lanes of that FU's grant bit.
- A variable FU keeps its valid asserted until it sees its `cdb_en`; the arbiter assumes no ordering among FUs.
- rr_ptr:
  - when at least one variable FU is granted, rr_ptr moves next cycle to (last granted variable local index + 1) mod (L+M);
  - otherwise it holds.
- Age counter per variable FU, 3 bits, saturating at STARVE_LIMIT:
  - +1 if requesting and not granted;
  - cleared to 0 if granted or not requesting.
- Reservation:
  - next fixed_slots_avail = NUM_LANES − min(count of FUs whose next age == STARVE_LIMIT, NUM_LANES);
  - the value is registered and valid the cycle after the starvation is observed.
  - The issue stage must issue ≤ fixed_slots_avail fixed ops this cycle. Those ops request the following cycle, leaving the reserved lanes free for variable FUs.
- Simultaneous events:
  - Grant and age update happen on the same edge.
  - A FU granted on the cycle it would saturate clears to 0 and does not contribute to the reservation.
- Reset mid-operation clears every counter, rr_ptr and the error flag. Variable FUs are reset alongside.

Test Plan:
- Reset held 2 cycles with all requests high -> complete_gnt_bus = 0 and fixed_slots_avail = 3 during reset; after release, alu_req = 3'b111 gives lanes 0,1,2 = ALU indices 3,4,5.
- alu_req = 3'b001, mult_cdb_valid = 2'b11, ldst_cdb_valid = 1, rr_ptr = 0 -> lane 0 = ALU0, lane1 = ldst (idx0), lane2 = mult0 (idx1); mult_cdb_en = 2'b01, ldst_cdb_en = 1; next rr_ptr = 2.
- Hold mult1 valid while 3 ALU requests fill every lane for 4 cycles -> mult1 age reaches 4; fixed_slots_avail = 2 next cycle; with issue honouring it, mult1 is granted on lane 2 the following cycle; age clears and fixed_slots_avail returns to 3.
- All three variable FUs valid, no fixed requests, for 2 cycles -> cycle 1 grants ldst, mult0, mult1; rr_ptr wraps to 0; cycle 2 repeats the same grants, with no duplicate lane bits.
- alu_req = 3'b111 plus branch_req = 1 -> branch ungranted; overcommit_err = 1 next cycle and stays 1 until reset.
- One variable request only (mult0) for 3 cycles, no fixed -> granted on lane 0 each cycle; lanes 1 and 2 are zero; ages stay 0.
